// File: rtl/pipeline_sequencer.sv
// Hazard/exception sequencer for the 5-stage pipeline.
// Drives PC and pipeline-register enables/flushes from ID/EX state.
module pipeline_sequencer #(
  parameter int MD_CYCLES = 32,
  parameter int HOLDOFF   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRs,
  input  logic       ID_UsesRt,
  input  logic       EX_MemRd,
  input  logic [4:0] EX_Rt,
  input  logic [2:0] ID_PCSrc,
  input  logic       EX_BranchTaken,
  input  logic       ID_Undef,
  input  logic       ID_MdStart,
  input  logic       ID_MdUse,
  input  logic       IRQ,
  input  logic       ker,
  output logic       PC_Wr,
  output logic       IFID_Wr,
  output logic       IFID_Flush,
  output logic       IDEX_Flush,
  output logic       EXMEM_Flush,
  output logic       Trap,
  output logic       TrapCause,
  output logic       MD_Busy
);

  typedef enum logic [1:0] {
    RUN,
    MDWAIT,
    HOLD
  } state_t;

  state_t     state, state_nxt;
  logic [5:0] md_cnt, md_nxt;
  logic [2:0] hold_cnt, hold_nxt;

  logic lu, ms, br, jp, exc, intr, busy;
  logic trap_go, md_acc;
  logic pc_wr, ifid_wr, ifid_f, idex_f;
  logic trap, cause;

  assign busy = (md_cnt != 6'd0);
  assign lu = EX_MemRd & (EX_Rt != 5'd0) &
              ((ID_UsesRs & (EX_Rt == ID_Rs)) |
               (ID_UsesRt & (EX_Rt == ID_Rt)));
  assign ms = busy & ID_MdUse;
  assign br = EX_BranchTaken;
  assign jp = (ID_PCSrc == 3'b010) | (ID_PCSrc == 3'b011);
  assign exc = ID_Undef &
               ((state == RUN) | (state == HOLD));
  assign intr = IRQ & ~ker & (state == RUN);
  assign trap_go = ~br & (exc | intr) & ~busy;

  // Single prioritised action per cycle
  always_comb begin
    pc_wr   = 1'b1;
    ifid_wr = 1'b1;
    ifid_f  = 1'b0;
    idex_f  = 1'b0;
    trap    = 1'b0;
    cause   = 1'b0;
    md_acc  = 1'b0;
    if (br) begin
      ifid_f = 1'b1;
      idex_f = 1'b1;
    end else if (trap_go) begin
      trap   = 1'b1;
      cause  = exc;
      ifid_f = 1'b1;
      idex_f = 1'b1;
    end else if (lu | ms) begin
      pc_wr   = 1'b0;
      ifid_wr = 1'b0;
      idex_f  = 1'b1;
    end else begin
      ifid_f = jp;
      md_acc = ID_MdStart & ~busy;
    end
  end

  // Reset overrides: freeze fetch, bubble everything
  always_comb begin
    PC_Wr       = pc_wr & reset;
    IFID_Wr     = ifid_wr & reset;
    IFID_Flush  = ifid_f | ~reset;
    IDEX_Flush  = idex_f | ~reset;
    EXMEM_Flush = (trap & cause) | ~reset;
    Trap        = trap & reset;
    TrapCause   = cause & reset;
    MD_Busy     = busy & reset;
  end

  // Next state and counter updates
  always_comb begin
    state_nxt = state;
    md_nxt    = md_cnt;
    hold_nxt  = (hold_cnt != 3'd0) ? hold_cnt - 3'd1 : 3'd0;
    unique case (state)
      RUN: ;
      MDWAIT: begin
        if (md_cnt != 6'd0) md_nxt = md_cnt - 6'd1;
        if (md_cnt <= 6'd1)
          state_nxt = (hold_nxt != 3'd0) ? HOLD : RUN;
      end
      HOLD: begin
        if (hold_nxt == 3'd0) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    if (trap_go) begin
      hold_nxt  = 3'(HOLDOFF);
      state_nxt = HOLD;
    end
    if (md_acc) begin
      md_nxt    = 6'(MD_CYCLES);
      state_nxt = MDWAIT;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      md_cnt   <= 6'd0;
      hold_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      md_cnt   <= md_nxt;
      hold_cnt <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer.
// MD_CYCLES=4, HOLDOFF=2.
module tb_pipeline_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_Rs, ID_Rt, EX_Rt;
  logic       ID_UsesRs, ID_UsesRt, EX_MemRd;
  logic [2:0] ID_PCSrc;
  logic       EX_BranchTaken, ID_Undef;
  logic       ID_MdStart, ID_MdUse, IRQ, ker;
  logic       PC_Wr, IFID_Wr, IFID_Flush, IDEX_Flush;
  logic       EXMEM_Flush, Trap, TrapCause, MD_Busy;

  int checks = 0;
  int errors = 0;

  pipeline_sequencer #(
    .MD_CYCLES(4),
    .HOLDOFF(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ID_Rs(ID_Rs),
    .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs),
    .ID_UsesRt(ID_UsesRt),
    .EX_MemRd(EX_MemRd),
    .EX_Rt(EX_Rt),
    .ID_PCSrc(ID_PCSrc),
    .EX_BranchTaken(EX_BranchTaken),
    .ID_Undef(ID_Undef),
    .ID_MdStart(ID_MdStart),
    .ID_MdUse(ID_MdUse),
    .IRQ(IRQ),
    .ker(ker),
    .PC_Wr(PC_Wr),
    .IFID_Wr(IFID_Wr),
    .IFID_Flush(IFID_Flush),
    .IDEX_Flush(IDEX_Flush),
    .EXMEM_Flush(EXMEM_Flush),
    .Trap(Trap),
    .TrapCause(TrapCause),
    .MD_Busy(MD_Busy)
  );

  always #5 clk = ~clk;

  // {PC_Wr, IFID_Flush, IDEX_Flush, EXMEM_Flush}
  function automatic logic [3:0] ctl();
    return {PC_Wr, IFID_Flush, IDEX_Flush, EXMEM_Flush};
  endfunction

  task automatic clr();
    ID_Rs = 0; ID_Rt = 0; EX_Rt = 0;
    ID_UsesRs = 0; ID_UsesRt = 0; EX_MemRd = 0;
    ID_PCSrc = 3'b000; EX_BranchTaken = 0;
    ID_Undef = 0; ID_MdStart = 0; ID_MdUse = 0;
    IRQ = 0; ker = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clr();
    @(negedge clk); #1;
    checks++;
    if (ctl() !== 4'b0111 || IFID_Wr !== 1'b0) begin
      errors++;
      $display("FAIL rst_ctl got %b/%b want 0111/0", ctl(), IFID_Wr);
    end
    checks++;
    if (Trap !== 1'b0 || MD_Busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_trap got %b%b want 00", Trap, MD_Busy);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (ctl() !== 4'b1000 || IFID_Wr !== 1'b1) begin
      errors++;
      $display("FAIL rel_ctl got %b/%b want 1000/1", ctl(), IFID_Wr);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clr();
    EX_MemRd = 1; EX_Rt = 8; ID_Rs = 8; ID_UsesRs = 1;
    #1;
    checks++;
    if (ctl() !== 4'b0010 || IFID_Wr !== 1'b0) begin
      errors++;
      $display("FAIL lu_rs got %b/%b want 0010/0", ctl(), IFID_Wr);
    end
    @(negedge clk);
    EX_MemRd = 0;
    #1;
    checks++;
    if (ctl() !== 4'b1000 || IFID_Wr !== 1'b1) begin
      errors++;
      $display("FAIL lu_after got %b/%b want 1000/1", ctl(), IFID_Wr);
    end
    @(negedge clk);
    EX_MemRd = 1; EX_Rt = 0; ID_Rs = 0;
    #1;
    checks++;
    if (ctl() !== 4'b1000 || IFID_Wr !== 1'b1) begin
      errors++;
      $display("FAIL lu_r0 got %b/%b want 1000/1", ctl(), IFID_Wr);
    end
    @(negedge clk);
    clr();
    EX_MemRd = 1; EX_Rt = 5; ID_Rt = 5; ID_UsesRt = 1;
    #1;
    checks++;
    if (ctl() !== 4'b0010 || IFID_Wr !== 1'b0) begin
      errors++;
      $display("FAIL lu_rt got %b/%b want 0010/0", ctl(), IFID_Wr);
    end
    @(negedge clk);
    ID_UsesRt = 0;
    #1;
    checks++;
    if (ctl() !== 4'b1000 || IFID_Wr !== 1'b1) begin
      errors++;
      $display("FAIL lu_nouse got %b/%b want 1000/1", ctl(), IFID_Wr);
    end
  endtask

  task automatic test_branch_jump();
    @(negedge clk);
    clr();
    EX_BranchTaken = 1; ID_PCSrc = 3'b010;
    #1;
    checks++;
    if (ctl() !== 4'b1110 || Trap !== 1'b0) begin
      errors++;
      $display("FAIL br_jp got %b/%b want 1110/0", ctl(), Trap);
    end
    @(negedge clk);
    EX_BranchTaken = 0; ID_PCSrc = 3'b011;
    #1;
    checks++;
    if (ctl() !== 4'b1100 || IFID_Wr !== 1'b1) begin
      errors++;
      $display("FAIL jr got %b/%b want 1100/1", ctl(), IFID_Wr);
    end
    @(negedge clk);
    ID_PCSrc = 3'b001;
    #1;
    checks++;
    if (ctl() !== 4'b1000) begin
      errors++;
      $display("FAIL pc001 got %b want 1000", ctl());
    end
  endtask

  task automatic test_muldiv();
    @(negedge clk);
    clr();
    ID_MdStart = 1; ID_MdUse = 1;
    #1;
    checks++;
    if (ctl() !== 4'b1000 || MD_Busy !== 1'b0) begin
      errors++;
      $display("FAIL md_issue got %b/%b want 1000/0", ctl(), MD_Busy);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      ID_MdStart = 0; ID_MdUse = 1;
      #1;
      checks++;
      if (MD_Busy !== 1'b1 || ctl() !== 4'b0010 ||
          IFID_Wr !== 1'b0) begin
        errors++;
        $display("FAIL md_stall t+%0d got %b/%b/%b want 1/0010/0",
                 k, MD_Busy, ctl(), IFID_Wr);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (MD_Busy !== 1'b0 || ctl() !== 4'b1000 ||
        IFID_Wr !== 1'b1) begin
      errors++;
      $display("FAIL md_done got %b/%b/%b want 0/1000/1",
               MD_Busy, ctl(), IFID_Wr);
    end
  endtask

  task automatic test_irq();
    @(negedge clk);
    clr();
    IRQ = 1; ker = 1;
    #1;
    checks++;
    if (Trap !== 1'b0 || ctl() !== 4'b1000) begin
      errors++;
      $display("FAIL irq_ker got %b/%b want 0/1000", Trap, ctl());
    end
    @(negedge clk);
    ker = 0;
    #1;
    checks++;
    if (Trap !== 1'b1 || TrapCause !== 1'b0 ||
        ctl() !== 4'b1110) begin
      errors++;
      $display("FAIL irq_trap got %b%b/%b want 10/1110",
               Trap, TrapCause, ctl());
    end
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (Trap !== 1'b0 || ctl() !== 4'b1000) begin
        errors++;
        $display("FAIL irq_hold t+%0d got %b/%b want 0/1000",
                 k, Trap, ctl());
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (Trap !== 1'b1 || TrapCause !== 1'b0) begin
      errors++;
      $display("FAIL irq_retake got %b%b want 10", Trap, TrapCause);
    end
    @(negedge clk);
    IRQ = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_priority();
    @(negedge clk);
    clr();
    ID_Undef = 1; IRQ = 1;
    #1;
    checks++;
    if (Trap !== 1'b1 || TrapCause !== 1'b1 ||
        ctl() !== 4'b1111) begin
      errors++;
      $display("FAIL exc_int got %b%b/%b want 11/1111",
               Trap, TrapCause, ctl());
    end
    @(negedge clk);
    IRQ = 0; ID_Undef = 1;
    #1;
    checks++;
    if (Trap !== 1'b1 || TrapCause !== 1'b1) begin
      errors++;
      $display("FAIL exc_hold got %b%b want 11", Trap, TrapCause);
    end
    @(negedge clk);
    clr();
    repeat (3) @(negedge clk);
    ID_Undef = 1; EX_BranchTaken = 1;
    #1;
    checks++;
    if (Trap !== 1'b0 || ctl() !== 4'b1110) begin
      errors++;
      $display("FAIL exc_br got %b/%b want 0/1110", Trap, ctl());
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    clr();
    ID_MdStart = 1;
    @(negedge clk);
    ID_MdStart = 0; ID_MdUse = 1;
    #1;
    checks++;
    if (MD_Busy !== 1'b1) begin
      errors++;
      $display("FAIL rm_busy got %b want 1", MD_Busy);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (MD_Busy !== 1'b0 || ctl() !== 4'b0111) begin
      errors++;
      $display("FAIL rm_abort got %b/%b want 0/0111", MD_Busy, ctl());
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (MD_Busy !== 1'b0 || ctl() !== 4'b1000 ||
        IFID_Wr !== 1'b1) begin
      errors++;
      $display("FAIL rm_release got %b/%b/%b want 0/1000/1",
               MD_Busy, ctl(), IFID_Wr);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_jump();
    test_muldiv();
    test_irq();
    test_priority();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
